// File: rtl/bubble_sort_engine_if.sv
// Stream bundle for the bubble sort engine: valid/ready load port, valid/ready sorted
// output port and the busy status flag.
interface bubble_sort_engine_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, busy
    );
endinterface

// File: rtl/bubble_sort_engine.sv
// Buffers N unsigned bytes, bubble-sorts them in place with one compare/swap per clock,
// then streams them out in ascending order.
module comparator_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       less,
    output logic       equal,
    output logic       greater
);
    always_comb begin
        less    = (a < b);
        equal   = (a == b);
        greater = (a > b);
    end
endmodule

module bubble_sort_engine #(
    parameter int unsigned N = 8
) (
    input logic                  clk,
    input logic                  rst,
    bubble_sort_engine_if.slave  bus
);
    localparam int unsigned IdxW = $clog2(N);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);
    localparam logic [IdxW-1:0] PassMax = IdxW'(N - 2);
    localparam logic [IdxW-1:0] One     = IdxW'(1);

    typedef enum logic [1:0] {StLoad, StSort, StDrain} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] wr_idx_q, wr_idx_d;
    logic [IdxW-1:0] rd_idx_q, rd_idx_d;
    logic [IdxW-1:0] pass_q, pass_d;
    logic [IdxW-1:0] pos_q, pos_d;
    logic            swapped_q, swapped_d;
    logic [7:0]      mem_q [N];

    logic [IdxW-1:0] pos_nxt;
    logic [IdxW-1:0] last_pos;
    logic [7:0]      cmp_a, cmp_b;
    logic            cmp_less, cmp_equal, cmp_greater;
    logic            any_swap;
    logic            mem_we;
    logic            swap_en;

    assign pos_nxt  = pos_q + One;
    assign last_pos = PassMax - pass_q;
    assign cmp_a    = mem_q[pos_q];
    assign cmp_b    = mem_q[pos_nxt];
    assign any_swap = swapped_q | cmp_greater;

    comparator_8 u_cmp (
        .a       (cmp_a),
        .b       (cmp_b),
        .less    (cmp_less),
        .equal   (cmp_equal),
        .greater (cmp_greater)
    );

    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        pass_d    = pass_q;
        pos_d     = pos_q;
        swapped_d = swapped_q;
        mem_we    = 1'b0;
        swap_en   = 1'b0;
        unique case (state_q)
            StLoad: begin
                if (bus.in_valid) begin
                    mem_we = 1'b1;
                    if (wr_idx_q == LastIdx) begin
                        wr_idx_d = '0;
                        state_d  = StSort;
                    end else begin
                        wr_idx_d = wr_idx_q + One;
                    end
                end
            end
            StSort: begin
                // Only a strict greater-than swaps, so equal keys keep their order.
                swap_en   = cmp_greater;
                swapped_d = any_swap;
                if (pos_q == last_pos) begin
                    pos_d     = '0;
                    swapped_d = 1'b0;
                    if (!any_swap || pass_q == PassMax) begin
                        pass_d  = '0;
                        state_d = StDrain;
                    end else begin
                        pass_d = pass_q + One;
                    end
                end else begin
                    pos_d = pos_nxt;
                end
            end
            StDrain: begin
                if (bus.out_ready) begin
                    if (rd_idx_q == LastIdx) begin
                        rd_idx_d = '0;
                        state_d  = StLoad;
                    end else begin
                        rd_idx_d = rd_idx_q + One;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StLoad;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            pass_q    <= '0;
            pos_q     <= '0;
            swapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            pass_q    <= pass_d;
            pos_q     <= pos_d;
            swapped_q <= swapped_d;
        end
    end

    // Buffer contents are don't-care after reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                mem_q[wr_idx_q] <= bus.in_data;
            end
            if (swap_en) begin
                mem_q[pos_q]   <= cmp_b;
                mem_q[pos_nxt] <= cmp_a;
            end
        end
    end

    always_comb begin
        bus.in_ready  = !rst && (state_q == StLoad);
        bus.out_valid = !rst && (state_q == StDrain);
        bus.busy      = !rst && (state_q != StLoad);
        bus.out_last  = bus.out_valid && (rd_idx_q == LastIdx);
        bus.out_data  = bus.out_valid ? mem_q[rd_idx_q] : 8'd0;
    end
endmodule

// File: tb/tb_bubble_sort_engine.sv
// Directed bench for bubble_sort_engine (N=8): sort results, SORT cycle counts,
// handshake stalls and mid-sort reset recovery.
module tb_bubble_sort_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;
    int   sort_cycles;
    logic [7:0] load_v [8];
    logic [7:0] exp_v [8];

    bubble_sort_engine_if bus ();

    bubble_sort_engine #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_assert++;
        assert (obs === req)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, req);
        end
    endtask

    // Inputs change on the negedge; the handshake completes on the following posedge.
    task automatic load_set(input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            chk("load_in_ready", bus.in_ready, 1'b1);
            chk("load_busy", bus.busy, 1'b0);
            bus.in_data  = load_v[i];
            bus.in_valid = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
    endtask

    task automatic wait_sort();
        int guard = 0;
        sort_cycles = 0;
        while (!bus.out_valid && guard < 100) begin
            if (bus.busy) sort_cycles++;
            chk("sort_in_ready", bus.in_ready, 1'b0);
            @(negedge clk);
            guard++;
        end
        chk("sort_done_in_bound", bus.out_valid, 1'b1);
    endtask

    task automatic drain_set(input bit stalls);
        logic [7:0] held;
        for (int i = 0; i < 8; i++) begin
            if (stalls && ($urandom_range(0, 1) == 1)) begin
                held = bus.out_data;
                bus.out_ready = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                chk("stall_hold", bus.out_data, held);
            end
            chk("drain_valid", bus.out_valid, 1'b1);
            chk("drain_data", bus.out_data, exp_v[i]);
            chk("drain_last", bus.out_last, (i == 7));
            chk("drain_in_ready", bus.in_ready, 1'b0);
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
        chk("post_drain_valid", bus.out_valid, 1'b0);
        chk("post_drain_busy", bus.busy, 1'b0);
        chk("post_drain_in_ready", bus.in_ready, 1'b1);
    endtask

    initial begin
        bus.in_data   = 8'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_out_data", bus.out_data, 8'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", bus.in_ready, 1'b1);

        // Mixed values, duplicates, and 251 (8'hFB) above 250 as unsigned
        load_v = '{8'd8, 8'd7, 8'd100, 8'd120, 8'd250, 8'd250, 8'd0, 8'd251};
        exp_v  = '{8'd0, 8'd7, 8'd8, 8'd100, 8'd120, 8'd250, 8'd250, 8'd251};
        load_set(1'b0);
        wait_sort();
        drain_set(1'b0);

        load_v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        exp_v  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load_set(1'b0);
        wait_sort();
        chk("ascending_cycles", sort_cycles, 7);
        drain_set(1'b0);

        load_v = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        load_set(1'b0);
        wait_sort();
        chk("descending_cycles", sort_cycles, 28);
        drain_set(1'b0);

        load_v = '{8'd250, 8'd250, 8'd250, 8'd250, 8'd250, 8'd250, 8'd250, 8'd250};
        exp_v  = '{8'd250, 8'd250, 8'd250, 8'd250, 8'd250, 8'd250, 8'd250, 8'd250};
        load_set(1'b0);
        wait_sort();
        chk("equal_cycles", sort_cycles, 7);
        drain_set(1'b0);

        // Input gaps and output stalls
        load_v = '{8'd200, 8'd15, 8'd15, 8'd99, 8'd3, 8'd255, 8'd128, 8'd64};
        exp_v  = '{8'd3, 8'd15, 8'd15, 8'd64, 8'd99, 8'd128, 8'd200, 8'd255};
        load_set(1'b1);
        wait_sort();
        drain_set(1'b1);

        // Reset partway through a descending sort
        load_v = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        load_set(1'b0);
        repeat (5) @(negedge clk);
        chk("mid_sort_busy", bus.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", bus.in_ready, 1'b0);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_out_valid", bus.out_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_in_ready", bus.in_ready, 1'b1);
        chk("after_rst_busy", bus.busy, 1'b0);
        load_v = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd0, 8'd2, 8'd4, 8'd6};
        exp_v  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd9};
        load_set(1'b0);
        wait_sort();
        drain_set(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
